op_dispatcher: RTL and testbench
================================

OP_DISPATCHER -- requirements
Module: op_dispatcher

Interface
REQ-001 SHALL have parameter NUM_HANDLERS, default 3, number of opcode handlers (0 linear G00/G01, 1 circular G02/G03, 2 mode G90/G91).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2^24-1, maximum clk_en cycles allowed in WAIT_DONE.
REQ-003 SHALL have parameter CNT_BITS, default 16, width of ops_done.
REQ-004 clk  in  1  system clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 clk_en  in  1  module enable; state advances only on edges where clk_en=1.
REQ-007 op_valid  in  1  upstream parser presents an opcode.
REQ-008 op_in  in  Op_st  opcode from the parser.
REQ-009 op_rdy  out  1  dispatcher can accept an opcode.
REQ-010 op  out  Op_st  latched current opcode, broadcast to all handlers.
REQ-011 h_trigger  out  NUM_HANDLERS  per-handler trigger.
REQ-012 h_rdy  in  NUM_HANDLERS  per-handler ready.
REQ-013 h_done  in  NUM_HANDLERS  per-handler done.
REQ-014 busy  out  1  an opcode is in flight.
REQ-015 err_unknown  out  1  one-cycle pulse: the accepted cmd maps to no handler.
REQ-016 err_timeout  out  1  one-cycle pulse: a handler exceeded TIMEOUT_CYCLES.
REQ-017 ops_done  out  CNT_BITS  count of completed opcodes.

Function
REQ-018 FSM states SHALL be IDLE, DISPATCH and WAIT_DONE; no transitions occur when clk_en=0.
REQ-019 op_rdy SHALL equal (state==IDLE); an accept occurs on an edge with clk_en & op_valid & op_rdy.
REQ-020 On accept, op SHALL latch op_in and sel SHALL latch cmd_to_handler(op_in.cmd); op holds its value until the next accept.
REQ-021 Accept with a valid sel SHALL move IDLE->DISPATCH; accept with an invalid sel SHALL keep IDLE, pulse err_unknown on the following cycle, and leave ops_done unchanged.
REQ-022 h_trigger[i] SHALL be combinational: (state==DISPATCH) & (i==sel) & h_rdy[i]; all other bits 0.
REQ-023 DISPATCH->WAIT_DONE SHALL occur on a clk_en edge with h_rdy[sel]=1; otherwise DISPATCH holds with no timeout counting.
REQ-024 In WAIT_DONE, h_done[sel]=1 on a clk_en edge SHALL return the FSM to IDLE and increment ops_done, which wraps from 2^CNT_BITS-1 to 0.
REQ-025 h_done from a non-selected handler, or any h_done outside WAIT_DONE, SHALL be ignored.
REQ-026 A timeout counter SHALL clear on entry to WAIT_DONE and increment per clk_en cycle.
REQ-027 Reaching TIMEOUT_CYCLES without done SHALL return the FSM to IDLE, pulse err_timeout for one cycle, and leave ops_done unchanged.
REQ-028 If done and timeout occur on the same edge, done SHALL win (count incremented, no err_timeout).
REQ-029 busy SHALL equal (state!=IDLE).
REQ-030 Accept-to-trigger latency SHALL be 1 clk_en cycle when the selected handler is ready.

Reset
REQ-031 Reset SHALL have priority over clk_en: state=IDLE, op=all-zero, sel=0, timeout counter=0, ops_done=0, err pulses=0.
REQ-032 Reset in DISPATCH or WAIT_DONE SHALL abandon the opcode; h_trigger SHALL be 0 from the reset cycle onward.

Structure
REQ-033 Package Dispatch_PKG SHALL hold NUM_HANDLERS, the handler index constants (HANDLER_LINEAR, HANDLER_CIRCULAR, HANDLER_MODE, HANDLER_NONE), and function cmd_to_handler.
REQ-034 Op_st and the OP_CMD_* constants SHALL come from Op_PKG unchanged.
REQ-035 The state machine SHALL be a sub-module op_dispatcher_fsm; the latch, counter and trigger decode stay in the top level.

Verification
REQ-036 G01 accepted with h_rdy[0]=1 -> h_trigger=3'b001 one cycle later; h_done[0] after 5 cycles -> IDLE, ops_done=1.
REQ-037 G02 with h_rdy[1]=0 for 4 cycles -> FSM holds DISPATCH with h_trigger=0; h_rdy[1] rises -> h_trigger=3'b010 for one cycle.
REQ-038 Unknown cmd -> err_unknown pulse, op_rdy stays 1, ops_done unchanged, h_trigger never set.
REQ-039 TIMEOUT_CYCLES=8, handler never done -> err_timeout after 8 clk_en cycles; done and timeout on the same edge -> no err, ops_done+1.
REQ-040 clk_en toggling 1-of-3 during a G00 -> same transition sequence; reset asserted in WAIT_DONE -> IDLE, ops_done=0; ops_done preset to 0xFFFF -> wraps to 0.

Source files
------------

// File: rtl/op_dispatcher_pkg.sv
// Handler numbering, FSM state type and the opcode-to-handler map.
package Dispatch_PKG;
    import Op_PKG::*;

    localparam int NUM_HANDLERS = 3;
    localparam int SEL_BITS     = 2;

    typedef logic [SEL_BITS-1:0] sel_t;

    localparam sel_t HANDLER_LINEAR   = 2'd0;
    localparam sel_t HANDLER_CIRCULAR = 2'd1;
    localparam sel_t HANDLER_MODE     = 2'd2;
    localparam sel_t HANDLER_NONE     = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DISPATCH  = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    function automatic sel_t cmd_to_handler(input logic [7:0] cmd);
        case (cmd)
            OP_CMD_G00, OP_CMD_G01: return HANDLER_LINEAR;
            OP_CMD_G02, OP_CMD_G03: return HANDLER_CIRCULAR;
            OP_CMD_G90, OP_CMD_G91: return HANDLER_MODE;
            default:                return HANDLER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/op_pkg.sv
// Opcode record exchanged between the G-code parser and the dispatch path.
package Op_PKG;

    localparam logic [7:0] OP_CMD_G00 = 8'd0;
    localparam logic [7:0] OP_CMD_G01 = 8'd1;
    localparam logic [7:0] OP_CMD_G02 = 8'd2;
    localparam logic [7:0] OP_CMD_G03 = 8'd3;
    localparam logic [7:0] OP_CMD_G90 = 8'd90;
    localparam logic [7:0] OP_CMD_G91 = 8'd91;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [15:0] arg_a;
        logic [15:0] arg_b;
    } Op_st;

endpackage

// File: rtl/op_dispatcher_if.sv
// Parser-side opcode handshake plus the handler trigger/ready/done fan-out.
interface op_dispatcher_if #(
    parameter int NUM_HANDLERS = 3,
    parameter int CNT_BITS     = 16
);
    import Op_PKG::*;

    logic                    op_valid;
    Op_st                    op_in;
    logic                    op_rdy;
    Op_st                    op;
    logic [NUM_HANDLERS-1:0] h_trigger;
    logic [NUM_HANDLERS-1:0] h_rdy;
    logic [NUM_HANDLERS-1:0] h_done;
    logic                    busy;
    logic                    err_unknown;
    logic                    err_timeout;
    logic [CNT_BITS-1:0]     ops_done;

    modport master (
        output op_valid, op_in, h_rdy, h_done,
        input  op_rdy, op, h_trigger, busy, err_unknown, err_timeout, ops_done
    );

    modport slave (
        input  op_valid, op_in, h_rdy, h_done,
        output op_rdy, op, h_trigger, busy, err_unknown, err_timeout, ops_done
    );

endinterface

// File: rtl/op_dispatcher_fsm.sv
// Purpose: IDLE/DISPATCH/WAIT_DONE sequencing of one opcode at a time.
// Latency: events are combinational on the current state, taken on clk_en edges.
// Backpressure: holds DISPATCH until the selected handler is ready; ignores input when busy.
module op_dispatcher_fsm
    import Dispatch_PKG::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   clk_en,
    input  logic   op_valid,
    input  logic   sel_ok,
    input  logic   sel_rdy,
    input  logic   sel_done,
    input  logic   tmo_hit,
    output state_e state,
    output logic   accept,
    output logic   done_evt,
    output logic   tmo_evt,
    output logic   unk_evt
);

    state_e state_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done_evt  = 1'b0;
        tmo_evt   = 1'b0;
        unk_evt   = 1'b0;
        if (clk_en) begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        accept = 1'b1;
                        if (sel_ok) state_nxt = DISPATCH;
                        else        unk_evt   = 1'b1;
                    end
                end
                DISPATCH: begin
                    if (sel_rdy) state_nxt = WAIT_DONE;
                end
                WAIT_DONE: begin
                    // done takes precedence over a timeout landing on the same edge
                    if (sel_done) begin
                        done_evt  = 1'b1;
                        state_nxt = IDLE;
                    end else if (tmo_hit) begin
                        tmo_evt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/op_dispatcher.sv
// Purpose: latch parser opcodes and route each to one handler, tracking completion.
// Latency: trigger one clk_en cycle after accept when the handler is ready.
// Backpressure: op_rdy low while an opcode is in flight; error flags pulse for one clk.
module op_dispatcher
    import Op_PKG::*;
    import Dispatch_PKG::*;
#(
    parameter int NUM_HANDLERS   = 3,
    parameter int TIMEOUT_CYCLES = (1 << 24) - 1,
    parameter int CNT_BITS       = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_en,
    op_dispatcher_if.slave  bus
);

    localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);

    state_e                  state;
    Op_st                    op_q;
    sel_t                    sel_q;
    sel_t                    new_sel;
    logic                    sel_ok;
    logic [NUM_HANDLERS-1:0] sel_mask;
    logic                    sel_rdy;
    logic                    sel_done;
    logic [TMO_BITS-1:0]     tmo_cnt;
    logic                    tmo_hit;
    logic [CNT_BITS-1:0]     ops_cnt;
    logic                    err_unk_q;
    logic                    err_tmo_q;
    logic                    accept;
    logic                    done_evt;
    logic                    tmo_evt;
    logic                    unk_evt;

    assign new_sel = cmd_to_handler(bus.op_in.cmd);
    assign sel_ok  = (new_sel != HANDLER_NONE) && (int'(new_sel) < NUM_HANDLERS);

    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < NUM_HANDLERS; i++) begin
            sel_mask[i] = (sel_q == sel_t'(i));
        end
    end

    assign sel_rdy  = |(sel_mask & bus.h_rdy);
    assign sel_done = |(sel_mask & bus.h_done);
    assign tmo_hit  = (tmo_cnt == TMO_BITS'(TIMEOUT_CYCLES - 1));

    op_dispatcher_fsm u_fsm (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .op_valid (bus.op_valid),
        .sel_ok   (sel_ok),
        .sel_rdy  (sel_rdy),
        .sel_done (sel_done),
        .tmo_hit  (tmo_hit),
        .state    (state),
        .accept   (accept),
        .done_evt (done_evt),
        .tmo_evt  (tmo_evt),
        .unk_evt  (unk_evt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            sel_q     <= HANDLER_LINEAR;
            tmo_cnt   <= '0;
            ops_cnt   <= '0;
            err_unk_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            err_unk_q <= unk_evt;
            err_tmo_q <= tmo_evt;
            if (accept) begin
                op_q  <= bus.op_in;
                sel_q <= new_sel;
            end
            // counter sits at zero outside WAIT_DONE so every entry starts fresh
            if (state != WAIT_DONE) begin
                tmo_cnt <= '0;
            end else if (clk_en) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (done_evt) begin
                ops_cnt <= ops_cnt + 1'b1;
            end
        end
    end

    // reset gates the trigger immediately, before the state register clears
    assign bus.h_trigger   = (state == DISPATCH && !reset) ? (sel_mask & bus.h_rdy) : '0;
    assign bus.op_rdy      = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.op          = op_q;
    assign bus.err_unknown = err_unk_q;
    assign bus.err_timeout = err_tmo_q;
    assign bus.ops_done    = ops_cnt;

endmodule

// File: tb/tb_op_dispatcher.sv
// Bench for op_dispatcher: directed vector table, counter wrap loop, randomized run vs. a model.
module tb_op_dispatcher;
    import Op_PKG::*;

    localparam int NH  = 3;
    localparam int TMO = 8;
    localparam int CB  = 4;

    logic clk = 1'b0;
    logic reset;
    logic clk_en;

    always #5 clk = ~clk;

    op_dispatcher_if #(.NUM_HANDLERS(NH), .CNT_BITS(CB)) bus ();

    op_dispatcher #(
        .NUM_HANDLERS   (NH),
        .TIMEOUT_CYCLES (TMO),
        .CNT_BITS       (CB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .bus    (bus)
    );

    typedef struct {
        logic       rst, en, vld;
        logic [7:0] cmd;
        logic [2:0] rdy, done;
        logic       e_rdy, e_busy;
        logic [2:0] e_trig;
        logic       e_unk, e_tmo;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model: one opcode in flight, described by what has happened to it
    logic       m_inflight, m_launched, m_err_unk, m_err_tmo;
    int         m_sel, m_waited, m_done;
    Op_st       m_op;

    function automatic void add(input logic rst, en, vld, input logic [7:0] cmd,
                                input logic [2:0] rdy, done, input logic e_rdy, e_busy,
                                input logic [2:0] e_trig, input logic e_unk, e_tmo,
                                input logic [3:0] e_cnt);
        vec_t v;
        v.rst = rst; v.en = en; v.vld = vld; v.cmd = cmd; v.rdy = rdy; v.done = done;
        v.e_rdy = e_rdy; v.e_busy = e_busy; v.e_trig = e_trig;
        v.e_unk = e_unk; v.e_tmo = e_tmo; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endfunction

    function automatic int handler_of(input logic [7:0] c);
        case (c)
            8'd0, 8'd1:   return 0;
            8'd2, 8'd3:   return 1;
            8'd90, 8'd91: return 2;
            default:      return -1;
        endcase
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %0h, want %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, en, vld, input Op_st o, input logic [2:0] rdy, done);
        reset        = rst;
        clk_en       = en;
        bus.op_valid = vld;
        bus.op_in    = o;
        bus.h_rdy    = rdy;
        bus.h_done   = done;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic check_outs(input string tag, input int idx, input logic e_rdy, e_busy,
                              input logic [2:0] e_trig, input logic e_unk, e_tmo, input logic [3:0] e_cnt);
        check({tag, ".op_rdy"},      idx, 64'(bus.op_rdy),      64'(e_rdy));
        check({tag, ".busy"},        idx, 64'(bus.busy),        64'(e_busy));
        check({tag, ".h_trigger"},   idx, 64'(bus.h_trigger),   64'(e_trig));
        check({tag, ".err_unknown"}, idx, 64'(bus.err_unknown), 64'(e_unk));
        check({tag, ".err_timeout"}, idx, 64'(bus.err_timeout), 64'(e_tmo));
        check({tag, ".ops_done"},    idx, 64'(bus.ops_done),    64'(e_cnt));
    endtask

    function automatic Op_st mk_op(input logic [7:0] c);
        Op_st o;
        o.cmd   = c;
        o.arg_a = 16'($urandom);
        o.arg_b = 16'($urandom);
        return o;
    endfunction

    task automatic model_edge(input logic rst, en, vld, input Op_st o, input logic [2:0] rdy, done);
        m_err_unk = 1'b0;
        m_err_tmo = 1'b0;
        if (rst) begin
            m_inflight = 1'b0; m_launched = 1'b0; m_waited = 0; m_done = 0; m_op = '0;
        end else if (en) begin
            if (!m_inflight) begin
                if (vld) begin
                    m_op  = o;
                    m_sel = handler_of(o.cmd);
                    if (m_sel < 0) m_err_unk = 1'b1;
                    else begin m_inflight = 1'b1; m_launched = 1'b0; end
                end
            end else if (!m_launched) begin
                if (rdy[m_sel]) begin m_launched = 1'b1; m_waited = 0; end
            end else begin
                m_waited++;
                if (done[m_sel]) begin
                    m_inflight = 1'b0;
                    m_done = (m_done + 1) % (1 << CB);
                end else if (m_waited == TMO) begin
                    m_inflight = 1'b0;
                    m_err_tmo = 1'b1;
                end
            end
        end
    endtask

    initial begin
        logic [7:0] cmd_tab [7];
        Op_st       r_op;
        logic       r_rst, r_en, r_vld;
        logic [2:0] r_rdy, r_done, e_trig;

        cmd_tab = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd90, 8'd91, 8'hA5};

        // ---- reset state ----
        drive(1, 1, 0, '0, 3'b000, 3'b000);
        repeat (3) cyc();
        #1;
        check("rst.op_rdy",   0, 64'(bus.op_rdy),   64'd1);
        check("rst.busy",     0, 64'(bus.busy),     64'd0);
        check("rst.ops_done", 0, 64'(bus.ops_done), 64'd0);
        check("rst.op",       0, 64'(bus.op),       64'd0);
        check("rst.err",      0, 64'({bus.err_unknown, bus.err_timeout}), 64'd0);

        // ---- directed vectors ----
        add(1,1,0,0,0,0, 1,0,0,0,0,0);
        // G01, linear handler ready, done after five waiting cycles
        add(0,1,1,1,1,0, 1,0,0,0,0,0);
        add(0,1,0,0,1,0, 0,1,1,0,0,0);
        for (int i = 0; i < 4; i++) add(0,1,0,0,1,0, 0,1,0,0,0,0);
        add(0,1,0,0,1,1, 0,1,0,0,0,0);
        add(0,1,0,0,0,0, 1,0,0,0,0,1);
        // G02 with circular handler not ready for four cycles
        add(0,1,1,2,0,0, 1,0,0,0,0,1);
        for (int i = 0; i < 4; i++) add(0,1,0,0,5,0, 0,1,0,0,0,1);
        add(0,1,0,0,2,0, 0,1,2,0,0,1);
        add(0,1,0,0,2,1, 0,1,0,0,0,1);
        add(0,1,0,0,0,2, 0,1,0,0,0,1);
        add(0,0,1,90,0,7, 1,0,0,0,0,2);
        // unknown command
        add(0,1,1,8'h55,7,0, 1,0,0,0,0,2);
        add(0,1,0,0,7,0, 1,0,0,1,0,2);
        add(0,1,0,0,7,0, 1,0,0,0,0,2);
        // G90 never done -> timeout after TMO waiting edges
        add(0,1,1,90,4,0, 1,0,0,0,0,2);
        add(0,1,0,0,4,0, 0,1,4,0,0,2);
        for (int i = 0; i < TMO; i++) add(0,1,0,0,4,0, 0,1,0,0,0,2);
        add(0,1,0,0,0,0, 1,0,0,0,1,2);
        add(0,1,0,0,0,0, 1,0,0,0,0,2);
        // G91 done on the very edge that would time out
        add(0,1,1,91,4,0, 1,0,0,0,0,2);
        add(0,1,0,0,4,0, 0,1,4,0,0,2);
        for (int i = 0; i < TMO-1; i++) add(0,1,0,0,4,0, 0,1,0,0,0,2);
        add(0,1,0,0,4,4, 0,1,0,0,0,2);
        add(0,1,0,0,0,0, 1,0,0,0,0,3);
        // G00 with clk_en active one cycle in three
        for (int i = 0; i < 2; i++) add(0,0,1,0,1,0, 1,0,0,0,0,3);
        add(0,1,1,0,1,0, 1,0,0,0,0,3);
        for (int i = 0; i < 2; i++) add(0,0,0,0,1,0, 0,1,1,0,0,3);
        add(0,1,0,0,1,0, 0,1,1,0,0,3);
        for (int i = 0; i < 2; i++) add(0,0,0,0,0,1, 0,1,0,0,0,3);
        add(0,1,0,0,0,1, 0,1,0,0,0,3);
        add(0,0,0,0,0,0, 1,0,0,0,0,4);
        // reset in DISPATCH, then reset (with clk_en low) in WAIT_DONE
        add(0,1,1,3,0,0, 1,0,0,0,0,4);
        add(1,1,0,0,2,0, 0,1,0,0,0,4);
        add(0,1,0,0,2,0, 1,0,0,0,0,0);
        add(0,1,1,0,1,0, 1,0,0,0,0,0);
        add(0,1,0,0,1,0, 0,1,1,0,0,0);
        add(0,1,0,0,0,1, 0,1,0,0,0,0);
        add(0,1,1,3,2,0, 1,0,0,0,0,1);
        add(0,1,0,0,2,0, 0,1,2,0,0,1);
        add(1,0,0,0,2,0, 0,1,0,0,0,1);
        add(0,1,0,0,2,2, 1,0,0,0,0,0);
        add(0,1,0,0,0,0, 1,0,0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].vld, mk_op(vecs[i].cmd), vecs[i].rdy, vecs[i].done);
            #1;
            check_outs("vec", i, vecs[i].e_rdy, vecs[i].e_busy, vecs[i].e_trig,
                       vecs[i].e_unk, vecs[i].e_tmo, vecs[i].e_cnt);
            cyc();
        end

        // ---- ops_done wrap: 17 back-to-back completions from zero ----
        for (int k = 1; k <= 17; k++) begin
            drive(0, 1, 1, mk_op(8'd1), 3'b001, 3'b000); cyc();
            drive(0, 1, 0, mk_op(8'd0), 3'b001, 3'b000); cyc();
            drive(0, 1, 0, mk_op(8'd0), 3'b000, 3'b001); cyc();
            drive(0, 1, 0, mk_op(8'd0), 3'b000, 3'b000);
            #1;
            check("wrap.ops_done", k, 64'(bus.ops_done), 64'(k % (1 << CB)));
            check("wrap.busy",     k, 64'(bus.busy),     64'd0);
            cyc();
        end

        // ---- randomized run against the model ----
        drive(1, 1, 0, '0, 3'b000, 3'b000);
        cyc();
        model_edge(1, 1, 0, '0, 3'b000, 3'b000);
        for (int c = 0; c < 4000; c++) begin
            r_rst = ($urandom_range(0, 249) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_vld = 1'($urandom_range(0, 1));
            r_op  = mk_op(cmd_tab[$urandom_range(0, 6)]);
            if ($urandom_range(0, 9) == 0) r_op.cmd = 8'($urandom);
            r_rdy = 3'($urandom);
            for (int b = 0; b < 3; b++) r_done[b] = ($urandom_range(0, 9) == 0);
            drive(r_rst, r_en, r_vld, r_op, r_rdy, r_done);
            #1;
            e_trig = 3'b000;
            if (m_inflight && !m_launched && !r_rst && r_rdy[m_sel]) e_trig = 3'(1 << m_sel);
            check_outs("rnd", c, !m_inflight, m_inflight, e_trig, m_err_unk, m_err_tmo, 4'(m_done));
            check("rnd.op", c, 64'(bus.op), 64'(m_op));
            model_edge(r_rst, r_en, r_vld, r_op, r_rdy, r_done);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
